// File: rtl/chan_scan_ctrl.sv
// Four-channel edge-count scanner: settle, gate, report per channel.
// Optional CHAN_SCAN_MASK_EN adds chan_mask to skip disabled channels.
module chan_scan_ctrl #(
    parameter int GATE_CYCLES   = 500,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(GATE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       sig_in,
    input  logic             start,
    input  logic             cont,
    input  logic             result_ready,
`ifdef CHAN_SCAN_MASK_EN
    input  logic [3:0]       chan_mask,
`endif
    output logic             busy,
    output logic [1:0]       ch_sel,
    output logic             result_valid,
    output logic [1:0]       result_ch,
    output logic [CNT_W-1:0] result_count
);

    localparam int MAXC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_GATE,
        S_REPORT
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ch_q, ch_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sig_d1_q, sig_d1_d;

    logic [3:0] mask;
    logic [1:0] first_ch, next_ch;
    logic       has_first, has_next;
    logic       cur_sig, edge_hit;

`ifdef CHAN_SCAN_MASK_EN
    assign mask = chan_mask;
`else
    assign mask = 4'hF;
`endif

    // Lowest enabled channel, and lowest enabled channel above the current one.
    always_comb begin
        first_ch  = 2'd0;
        has_first = 1'b0;
        next_ch   = 2'd0;
        has_next  = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                first_ch  = 2'(i);
                has_first = 1'b1;
            end
            if (mask[i] && (i > int'(ch_q))) begin
                next_ch  = 2'(i);
                has_next = 1'b1;
            end
        end
    end

    assign cur_sig  = sig_in[ch_q];
    assign edge_hit = cur_sig ^ sig_d1_q;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        tmr_d    = tmr_q;
        cnt_d    = cnt_q;
        sig_d1_d = sig_d1_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && has_first) begin
                    state_d  = S_SETTLE;
                    ch_d     = first_ch;
                    tmr_d    = TW'(SETTLE_CYCLES - 1);
                    cnt_d    = '0;
                    sig_d1_d = 1'b0;
                end
            end
            S_SETTLE: begin
                sig_d1_d = cur_sig;
                if (tmr_q == '0) begin
                    state_d = S_GATE;
                    tmr_d   = TW'(GATE_CYCLES - 1);
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_GATE: begin
                sig_d1_d = cur_sig;
                if (edge_hit && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (tmr_q == '0) begin
                    state_d = S_REPORT;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_REPORT: begin
                if (result_ready) begin
                    if (has_next || (cont && has_first)) begin
                        state_d = S_SETTLE;
                        ch_d    = has_next ? next_ch : first_ch;
                        tmr_d   = TW'(SETTLE_CYCLES - 1);
                        cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ch_q     <= 2'd0;
            tmr_q    <= '0;
            cnt_q    <= '0;
            sig_d1_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            sig_d1_q <= sig_d1_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign ch_sel       = ch_q;
    assign result_valid = (state_q == S_REPORT);
    assign result_ch    = ch_q;
    assign result_count = cnt_q;

endmodule

// File: tb/tb_chan_scan_ctrl.sv
// Scoreboard bench for chan_scan_ctrl: directed scans, stall, reset, saturation.
// Mask cases run only when CHAN_SCAN_MASK_EN is defined.
module tb_chan_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, start_s, cont, result_ready;
    logic [3:0] sig_in;
`ifdef CHAN_SCAN_MASK_EN
    logic [3:0] chan_mask;
`endif

    logic       busy, result_valid;
    logic [1:0] ch_sel, result_ch;
    logic [3:0] result_count;

    logic       busy_s, result_valid_s;
    logic [1:0] ch_sel_s, result_ch_s;
    logic [7:0] result_count_s;

    chan_scan_ctrl #(.GATE_CYCLES(10), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .start(start),
        .cont(cont), .result_ready(result_ready),
`ifdef CHAN_SCAN_MASK_EN
        .chan_mask(chan_mask),
`endif
        .busy(busy), .ch_sel(ch_sel), .result_valid(result_valid),
        .result_ch(result_ch), .result_count(result_count)
    );

    chan_scan_ctrl #(.GATE_CYCLES(500), .SETTLE_CYCLES(2), .CNT_W(8)) dut_s (
        .clk(clk), .reset(reset), .sig_in(sig_in), .start(start_s),
        .cont(cont), .result_ready(result_ready),
`ifdef CHAN_SCAN_MASK_EN
        .chan_mask(chan_mask),
`endif
        .busy(busy_s), .ch_sel(ch_sel_s), .result_valid(result_valid_s),
        .result_ch(result_ch_s), .result_count(result_count_s)
    );

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] cnt;
    } exp_t;

    exp_t q_m[$];
    exp_t q_s[$];
    exp_t em, es;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mode    = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Signal patterns: 0 ch0 toggles/cycle, 1 ch2 high others toggle/2 cycles,
    // 2 all toggle/cycle.
    initial begin
        sig_in = 4'h0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (mode)
                0: sig_in = {3'b000, cyc[0]};
                1: sig_in = {cyc[1], 1'b1, cyc[1], cyc[1]};
                2: sig_in = {4{cyc[0]}};
                default: sig_in = 4'h0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset && result_valid && result_ready) begin
            if (q_m.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got ch=%0d count=%0d expected none",
                         result_ch, result_count);
            end else begin
                em = q_m.pop_front();
                chk("res_ch", result_ch, em.ch);
                chk("res_count", result_count, em.cnt);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && result_valid_s && result_ready) begin
            if (q_s.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_sat_result: got ch=%0d count=%0d expected none",
                         result_ch_s, result_count_s);
            end else begin
                es = q_s.pop_front();
                chk("sat_ch", result_ch_s, es.ch);
                chk("sat_count", result_count_s, es.cnt);
            end
        end
    end

    task automatic push4(input int c0, input int c1, input int c2, input int c3);
        q_m.push_back({2'd0, 16'(c0)});
        q_m.push_back({2'd1, 16'(c1)});
        q_m.push_back({2'd2, 16'(c2)});
        q_m.push_back({2'd3, 16'(c3)});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        while ((busy || busy_s) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, busy | busy_s, 0);
    endtask

    initial begin
        int  n;
        int  ok;
        logic [1:0] rc;
        logic [3:0] rn;

        reset        = 1'b1;
        start        = 1'b0;
        start_s      = 1'b0;
        cont         = 1'b0;
        result_ready = 1'b1;
`ifdef CHAN_SCAN_MASK_EN
        chan_mask    = 4'hF;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_ch_sel", ch_sel, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_res_ch", result_ch, 0);
        chk("rst_res_count", result_count, 0);

        // First-result latency with ch0 toggling every cycle
        mode = 0;
        push4(10, 0, 0, 0);
        start = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end while (!result_valid && n < 60);
        chk("latency", n, 13);
        wait_idle("idle_after_scan_a", 200);
        chk("queue_a", q_m.size(), 0);

        // Mixed patterns, plus a start pulse while busy that must be ignored
        mode = 1;
        push4(5, 5, 0, 5);
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        pulse_start();
        wait_idle("idle_after_scan_b", 200);
        chk("queue_b", q_m.size(), 0);

        // Back-pressure: hold ready low for 20 cycles in REPORT
        mode = 0;
        result_ready = 1'b0;
        push4(10, 0, 0, 0);
        pulse_start();
        n = 0;
        while (!result_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_reach_report", result_valid, 1);
        rc = result_ch;
        rn = result_count;
        ok = 1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (!result_valid || result_ch != rc || result_count != rn) ok = 0;
        end
        chk("stall_hold", ok, 1);
        chk("stall_queue", q_m.size(), 4);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_valid_drop", result_valid, 0);
        chk("stall_next_ch", ch_sel, 1);
        chk("stall_busy", busy, 1);
        chk("stall_single_pop", q_m.size(), 3);
        wait_idle("idle_after_stall", 200);
        chk("queue_c", q_m.size(), 0);

        // Reset in the middle of channel 1's gate window
        mode = 0;
        q_m.push_back({2'd0, 16'd10});
        pulse_start();
        n = 0;
        while (ch_sel != 2'd1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_ch1", ch_sel, 1);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_ch_sel", ch_sel, 0);
        chk("midrst_valid", result_valid, 0);
        chk("midrst_res_ch", result_ch, 0);
        chk("midrst_res_count", result_count, 0);
        chk("midrst_queue", q_m.size(), 0);
        push4(10, 0, 0, 0);
        pulse_start();
        chk("restart_ch0", ch_sel, 0);
        wait_idle("idle_after_restart", 200);
        chk("queue_d", q_m.size(), 0);

        // Reset wins over a simultaneous start
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        chk("rst_over_start", busy, 0);

        // Saturation on the 500-cycle, 8-bit instance
        mode = 2;
        for (int i = 0; i < 4; i++) q_s.push_back({2'(i), 16'd255});
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        wait_idle("idle_after_sat", 3000);
        chk("queue_sat", q_s.size(), 0);

`ifdef CHAN_SCAN_MASK_EN
        // Masked continuous scan 1,3,1,3 then stop
        mode = 2;
        chan_mask = 4'b1010;
        cont = 1'b1;
        q_m.push_back({2'd1, 16'd10});
        q_m.push_back({2'd3, 16'd10});
        q_m.push_back({2'd1, 16'd10});
        q_m.push_back({2'd3, 16'd10});
        pulse_start();
        chk("mask_first_ch", ch_sel, 1);
        n = 0;
        while (q_m.size() > 1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        cont = 1'b0;
        wait_idle("idle_after_mask", 200);
        chk("queue_mask", q_m.size(), 0);
        chan_mask = 4'b0000;
        pulse_start();
        repeat (2) @(posedge clk);
        #1;
        chk("mask_zero_busy", busy, 0);
        chan_mask = 4'hF;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/chan_scan_ctrl.md
CHAN_SCAN_CTRL -- requirements
Module: chan_scan_ctrl

Interface
REQ-001 Parameter GATE_CYCLES, default 500: length of one edge-counting gate window, in clk cycles.
REQ-002 Parameter SETTLE_CYCLES, default 4: idle cycles after each channel switch, before the gate opens; minimum 1.
REQ-003 Parameter CNT_W, default $clog2(GATE_CYCLES+1): width of the edge count.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sig_in  input  4  one measured signal per channel, already synchronous to clk.
REQ-007 start  input  1  single-cycle pulse that begins a scan.
REQ-008 cont  input  1  1 = restart at channel 0 after channel 3; 0 = go to IDLE after channel 3.
REQ-009 result_ready  input  1  consumer accepts the presented result.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 ch_sel  output  2  channel currently routed to the edge detector.
REQ-012 result_valid  output  1  a result is presented.
REQ-013 result_ch  output  2  channel that the presented result belongs to.
REQ-014 result_count  output  CNT_W  number of edges counted in the gate window.

Function
REQ-015 FSM states are IDLE, SETTLE, GATE and REPORT; busy is 0 only in IDLE.
REQ-016 IDLE, start=1: next state SETTLE, ch_sel = first enabled channel, counters cleared.
REQ-017 SETTLE lasts exactly SETTLE_CYCLES cycles, then moves to GATE.
  - Each SETTLE cycle registers sig_in[ch_sel] into sig_d1.
REQ-018 GATE lasts exactly GATE_CYCLES cycles.
  - Each GATE cycle: edge = sig_in[ch_sel] XOR sig_d1; count increments when edge=1; sig_d1 updates.
REQ-019 The count saturates at 2^CNT_W-1 and never wraps.
REQ-020 After the last GATE cycle, the block enters REPORT with:
  - result_valid=1
  - result_ch=ch_sel
  - result_count = final count, including any edge in the last gate cycle.
REQ-021 result_valid, result_ch and result_count hold stable until a cycle in which result_valid=1 and result_ready=1.
  - result_ready already high on the first REPORT cycle completes the handshake in that cycle.
REQ-022 On handshake, result_valid deasserts on the next cycle and the state advances:
  - next enabled channel -> SETTLE
  - after the last enabled channel: cont=1 -> SETTLE on the first enabled channel; cont=0 -> IDLE.
  - cont is sampled in the handshake cycle.
REQ-023 start outside IDLE is ignored.
REQ-024 sig_in activity outside GATE never changes the count.
REQ-025 Minimum per-channel latency: start to first result_valid = 1 + SETTLE_CYCLES + GATE_CYCLES cycles.

Reset
REQ-026 reset=1 at any clock edge forces the following, regardless of state or a pending handshake:
  - state IDLE, busy=0, ch_sel=0, result_valid=0, result_ch=0, result_count=0, count=0, sig_d1=0.
REQ-027 A result that has not been accepted when reset asserts is discarded.
REQ-028 reset has priority over start in the same cycle.

Configuration
REQ-029 With CHAN_SCAN_MASK_EN defined, the block has an extra input chan_mask (4 bits, 1 = channel enabled), sampled on the start cycle and at each channel advance.
  - Disabled channels are skipped; "first" and "last" refer to enabled channels.
  - chan_mask=0 on start: block stays in IDLE.
  - chan_mask=0 at the wrap point with cont=1: block goes to IDLE.
REQ-030 Without CHAN_SCAN_MASK_EN, chan_mask does not exist and all four channels are scanned in order 0,1,2,3.

Verification
REQ-031 GATE_CYCLES=10, SETTLE_CYCLES=2; sig_in[0] toggles every cycle; start, result_ready=1 -> result_valid at cycle start+13, result_ch=0, result_count=10.
REQ-032 sig_in[2] constant 1, other channels toggle every 2 cycles; result_ready=1, cont=0 -> four results: ch0=5, ch1=5, ch2=0, ch3=5; then busy=0.
REQ-033 result_ready held 0 for 20 cycles in REPORT -> result_valid, result_ch and result_count stay unchanged; ready=1 -> one handshake, next channel enters SETTLE.
REQ-034 GATE_CYCLES=500, sig_in[1] toggles every cycle, CNT_W overridden to 8 -> result_count=255 (saturated).
REQ-035 reset pulsed mid-GATE on channel 1 -> next cycle state IDLE, all outputs 0; a new start scans from channel 0.
REQ-036 CHAN_SCAN_MASK_EN defined, chan_mask=4'b1010, cont=1 -> result_ch sequence 1,3,1,3...; chan_mask=0 on start -> busy stays 0.
